// File: rtl/pht_ctrl.sv
// Pattern history table controller for the IFU branch predictor: IF lookups,
// buffered EX updates applied as one read-modify-write per cycle, and a table-init sweep.
module pht_ctrl #(
   parameter int unsigned IDX_W      = 6,
   parameter int unsigned UPD_DEPTH  = 4,
   parameter logic [1:0]  INIT_STATE = 2'b01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             lookup_valid_i,
   input  logic [IDX_W-1:0] lookup_idx_i,
   output logic             pred_valid_o,
   output logic [1:0]       pred_state_o,
   output logic             pred_taken_o,
   input  logic             upd_valid_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i,
   output logic             upd_ready_o,
   output logic             busy_o
);

   localparam int unsigned ENTRIES = 1 << IDX_W;
   localparam int unsigned PTR_W   = $clog2(UPD_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;

   typedef enum logic {S_INIT, S_RUN} state_t;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             taken;
   } upd_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
   logic [1:0]       pht_q [ENTRIES];
   upd_t             fifo_q [UPD_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             full, empty, push, pop;
   upd_t             head;
   logic [1:0]       head_cnt, rmw_cnt;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [1:0]       wr_data;

   assign full         = (cnt_q == CNT_W'(UPD_DEPTH));
   assign empty        = (cnt_q == '0);
   assign upd_ready_o  = !full;
   assign busy_o       = (state_q == S_INIT);
   assign pred_taken_o = pred_state_o[1];
   assign head         = fifo_q[rd_ptr_q];
   assign head_cnt     = pht_q[head.idx];

   // 2-bit saturating counter step for the FIFO head
   always_comb begin
      rmw_cnt = head_cnt;
      if (head.taken) begin
         if (head_cnt != 2'b11) rmw_cnt = head_cnt + 2'b01;
      end else begin
         if (head_cnt != 2'b00) rmw_cnt = head_cnt - 2'b01;
      end
   end

   // Sequencer: init sweep owns the write port in S_INIT, RMW owns it in S_RUN
   always_comb begin
      state_d    = state_q;
      init_ptr_d = init_ptr_q;
      pop        = 1'b0;
      wr_en      = 1'b0;
      wr_idx     = init_ptr_q;
      wr_data    = INIT_STATE;
      push       = upd_valid_i && !full;
      case (state_q)
         S_INIT: begin
            wr_en      = 1'b1;
            init_ptr_d = init_ptr_q + 1'b1;
            if (init_ptr_q == IDX_W'(ENTRIES - 1)) state_d = S_RUN;
         end
         S_RUN: begin
            if (!empty) begin
               pop     = 1'b1;
               wr_en   = 1'b1;
               wr_idx  = head.idx;
               wr_data = rmw_cnt;
            end
         end
         default: state_d = S_INIT;
      endcase
      if (flush_i) begin
         state_d    = S_INIT;
         init_ptr_d = '0;
         push       = 1'b0;
         pop        = 1'b0;
         if (state_q == S_RUN) wr_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_INIT;
         init_ptr_q <= '0;
      end else begin
         state_q    <= state_d;
         init_ptr_q <= init_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) pht_q[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= '{idx: upd_idx_i, taken: upd_taken_i};
   end

   // Pointers wrap naturally since the depth is a power of two
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      end
   end

   // Lookup reads the table as it stood at the start of the cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_valid_o <= 1'b0;
         pred_state_o <= 2'b00;
      end else begin
         pred_valid_o <= lookup_valid_i;
         if (lookup_valid_i) begin
            pred_state_o <= (state_q == S_INIT || flush_i) ? INIT_STATE : pht_q[lookup_idx_i];
         end
      end
   end

endmodule
